// File: rtl/circular_buffer.sv
// Circular FIFO buffer with first-word-fall-through output, occupancy count
// and sticky overflow/underflow flags.
//
// Handshake: a write is accepted on a rising clk edge iff wen=1 and ready=1.
// A read is accepted on a rising clk edge iff ren=1 and valid=1. dout shows
// the head word whenever valid=1. A request that is presented while its
// qualifier is low is dropped, and it sets the matching sticky flag.
module circular_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [WIDTH-1:0]  din,
  output logic              ready,
  input  logic              ren,
  output logic [WIDTH-1:0]  dout,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Space and data availability come straight from the occupancy register.
  always_comb begin
    ready = (count_q != FULL_COUNT);
    valid = (count_q != '0);
    wr_ok = wen & ready;
    rd_ok = ren & valid;
    dout  = mem_q[rptr_q];
    count = count_q;
    ovf   = ovf_q;
    udf   = udf_q;
  end

  // Next-state for pointers, occupancy and sticky flags; pointers wrap by rollover.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wen && !ready) ovf_d = 1'b1;
    if (ren && !valid) udf_d = 1'b1;
  end

  // Control state register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive reset, writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: doc/circular_buffer.md
CIRCULAR_BUFFER -- requirements
Module: circular_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, pointer width; DEPTH = 2**ADDR_W entries (8 by default).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wen, input, 1, write request from the upstream buffer write controller.
REQ-006 SHALL have port din, input, WIDTH, write data; sampled when a write is accepted.
REQ-007 SHALL have port ready, output, 1, space available (not full); drives the write controller's ready input.
REQ-008 SHALL have port ren, input, 1, read request from the downstream consumer.
REQ-009 SHALL have port dout, output, WIDTH, head-of-buffer data, first-word-fall-through.
REQ-010 SHALL have port valid, output, 1, buffer not empty; dout meaningful only while valid=1.
REQ-011 SHALL have port count, output, ADDR_W+1, current occupancy, 0..DEPTH.
REQ-012 SHALL have port ovf, output, 1, sticky flag: a write was attempted while full.
REQ-013 SHALL have port udf, output, 1, sticky flag: a read was attempted while empty.

Function
REQ-014 SHALL hold DEPTH x WIDTH storage, write pointer wptr, read pointer rptr (ADDR_W bits each) and count register.
REQ-015 SHALL drive ready = (count != DEPTH) and valid = (count != 0), both combinational from count.
REQ-016 SHALL accept a write (wr_ok) in a cycle iff wen=1 and ready=1; it stores din at mem[wptr] and increments wptr at the clock edge.
REQ-017 SHALL accept a read (rd_ok) in a cycle iff ren=1 and valid=1; it increments rptr at the clock edge.
REQ-018 SHALL drive dout = mem[rptr] combinationally; no read latency; a written word appears on dout the cycle after the write if the buffer was empty.
REQ-019 SHALL wrap wptr and rptr from DEPTH-1 to 0 by natural ADDR_W-bit rollover.
REQ-020 SHALL update count: +1 if wr_ok only, -1 if rd_ok only, unchanged if both or neither.
REQ-021 SHALL, when full with wen=1 and ren=1 in the same cycle, accept only the read (ready=0 gates the write); count becomes DEPTH-1; ovf sets.
REQ-022 SHALL, when empty with wen=1 and ren=1 in the same cycle, accept only the write (valid=0 gates the read); count becomes 1; udf sets.
REQ-023 SHALL set ovf on any cycle with wen=1 and ready=0; ovf holds until reset.
REQ-024 SHALL set udf on any cycle with ren=1 and valid=0; udf holds until reset.
REQ-025 SHALL leave mem unchanged on rejected writes and pointers unchanged on rejected requests.
REQ-026 SHALL preserve strict FIFO order across any number of wrap-arounds.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear wptr, rptr, count, ovf and udf to 0; mem contents are not cleared.
REQ-028 SHALL give reset priority over simultaneous wen/ren; requests in the reset cycle are discarded and flags do not set.
REQ-029 SHALL present ready=1, valid=0, count=0, ovf=0, udf=0 in the cycle after reset; dout is don't-care until valid=1.
REQ-030 SHALL, on reset mid-operation (e.g. count=5), discard all stored words; the next read returns only data written after reset.

Verification
REQ-031 Fill: reset, write 0x0001..0x0008 on consecutive cycles -> count 1..8, ready=0 after 8th write, valid=1, dout=0x0001.
REQ-032 Overflow: at full, wen=1 with din=0xDEAD, ren=0 -> count stays 8, ovf=1, draining yields 0x0001..0x0008 with no 0xDEAD.
REQ-033 Underflow: empty, ren=1 -> udf=1, count=0, rptr unchanged; subsequent write 0x00AA -> dout=0x00AA next cycle.
REQ-034 Simultaneous: count=3, wen=ren=1 for 20 cycles with incrementing din -> count stays 3, outputs in order, pointers wrap twice.
REQ-035 Edge simultaneous: full with wen=ren=1 -> count=7, ovf=1; empty with wen=ren=1 -> count=1, udf=1.
REQ-036 Reset mid-run: count=5, rst=1 with wen=ren=1 -> next cycle count=0, valid=0, ready=1, ovf=udf=0.
